hbi_dout_pipe: RTL and testbench

- Parametrised host-bus read-data output stage; next generation of the HBI data-out path.
- Selects one of NSRC read-data sources and swizzles it (bit/byte order).
- Buffers beats in a DEPTH-entry FIFO behind a registered output stage, so source data survives irdy_n stalls.
- Generates one even-parity bit per 32-bit lane (PAR/PAR64), delayed one clock per PCI; also carries PCI-master write data.

---
 rtl/hbi_dout_pipe.sv | 182 ++++++++++++++++++
 tb/tb_hbi_dout_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbi_dout_pipe.sv
// Host-bus read-data output stage: source select, per-lane swizzle, DEPTH-entry
// FIFO behind a registered AD output, and per-lane PCI parity one clock later.
`timescale 1ns/1ps
`default_nettype none

module hbi_dout_pipe #(
  parameter int unsigned DW    = 32,
  parameter int unsigned NSRC  = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   hb_clk,
  input  logic                   sys_reset_n,
  input  logic [NSRC*DW-1:0]     src_data,
  input  logic [NSRC-1:0]        src_sel_n,
  input  logic [2:0]             swizzler_ctrl,
  input  logic                   rd_valid,
  output logic                   rd_ready,
  input  logic                   flush,
  input  logic                   trdy_n,
  input  logic                   irdy_n,
  input  logic [DW/8-1:0]        hb_byte_ens,
  input  logic                   mst_ad_oe,
  input  logic [DW-1:0]          mst_ad_out,
  input  logic [DW/8-1:0]        mst_c_be,
  output logic [DW-1:0]          blkbird_dout,
  output logic                   dout_valid,
  output logic [DW/32-1:0]       par_out,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int unsigned LANES = DW / 32;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic [DW-1:0]    r_dout;
  logic             r_dout_valid;
  logic [LANES-1:0] r_par;
  logic             r_oe_q;

  logic [DW-1:0]    w_sel_data;
  logic [DW-1:0]    w_swz;
  logic             w_full;
  logic             w_empty;
  logic             w_beat_done;
  logic             w_rd_mode;
  logic             w_ready;
  logic             w_push;
  logic             w_load;
  logic             w_pop;
  logic             w_bypass;
  logic             w_fifo_wr;
  logic [LANES-1:0] w_par_nxt;

  // Bit reverse within each byte first, then reorder bytes inside each 32-bit lane.
  function automatic logic [DW-1:0] f_swizzle(input logic [DW-1:0] d,
                                               input logic [2:0]    ctrl);
    logic [DW-1:0] br;
    logic [DW-1:0] res;
    logic [7:0]    b0, b1, b2, b3;
    br = d;
    if (ctrl[0]) begin
      for (int unsigned j = 0; j < DW / 8; j++) begin
        for (int unsigned b = 0; b < 8; b++) begin
          br[j*8 + b] = d[j*8 + 7 - b];
        end
      end
    end
    res = br;
    for (int unsigned l = 0; l < LANES; l++) begin
      b0 = br[l*32      +: 8];
      b1 = br[l*32 + 8  +: 8];
      b2 = br[l*32 + 16 +: 8];
      b3 = br[l*32 + 24 +: 8];
      case (ctrl[2:1])
        2'b01:   res[l*32 +: 32] = {b2, b3, b0, b1};
        2'b10:   res[l*32 +: 32] = {b1, b0, b3, b2};
        2'b11:   res[l*32 +: 32] = {b0, b1, b2, b3};
        default: res[l*32 +: 32] = {b3, b2, b1, b0};
      endcase
    end
    return res;
  endfunction

  // Lowest asserted select wins; with none asserted the last source is used.
  always_comb begin
    w_sel_data = src_data[(NSRC-1)*DW +: DW];
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (!src_sel_n[i-1]) w_sel_data = src_data[(i-1)*DW +: DW];
    end
  end

  assign w_swz = f_swizzle(w_sel_data, swizzler_ctrl);

  assign w_full      = (r_cnt == CW'(DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign w_beat_done = r_dout_valid && !trdy_n && !irdy_n;
  assign w_rd_mode   = !mst_ad_oe || w_beat_done;

  // A completing beat frees a slot this clock, so a full FIFO can still accept.
  assign w_ready     = !mst_ad_oe && (!w_full || w_beat_done);
  assign w_push      = rd_valid && w_ready && !flush;
  assign w_load      = w_rd_mode && (!r_dout_valid || w_beat_done) && !flush;
  assign w_pop       = w_load && !w_empty;
  assign w_bypass    = w_load && w_empty && w_push;
  assign w_fifo_wr   = w_push && !w_bypass;

  always_comb begin
    w_par_nxt = r_par;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (r_oe_q) begin
        w_par_nxt[k] = ^{r_dout[k*32 +: 32], mst_c_be[k*4 +: 4]};
      end else if (w_beat_done) begin
        w_par_nxt[k] = ^{r_dout[k*32 +: 32], hb_byte_ens[k*4 +: 4]};
      end
    end
  end

  always_ff @(posedge hb_clk) begin
    if (w_fifo_wr) r_mem[r_wptr] <= w_swz;
  end

  always_ff @(posedge hb_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_fifo_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CW'(w_fifo_wr) - CW'(w_pop);
    end
  end

  always_ff @(posedge hb_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (flush) begin
      r_dout_valid <= 1'b0;
      if (mst_ad_oe) r_dout <= mst_ad_out;
    end else if (!w_rd_mode) begin
      r_dout <= mst_ad_out;
    end else if (w_load) begin
      if (w_pop) begin
        r_dout       <= r_mem[r_rptr];
        r_dout_valid <= 1'b1;
      end else if (w_bypass) begin
        r_dout       <= w_swz;
        r_dout_valid <= 1'b1;
      end else begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge hb_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_par  <= '0;
      r_oe_q <= 1'b0;
    end else begin
      r_par  <= w_par_nxt;
      r_oe_q <= mst_ad_oe;
    end
  end

  assign rd_ready     = w_ready;
  assign blkbird_dout = r_dout;
  assign dout_valid   = r_dout_valid;
  assign par_out      = r_par;
  assign fifo_cnt     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hbi_dout_pipe.sv
// Drives a 32-bit and a 64-bit hbi_dout_pipe in lockstep and compares both
// against a queue-style reference model of the read/master/parity behaviour.
`timescale 1ns/1ps

module tb_hbi_dout_pipe;

  localparam int NSRC  = 6;
  localparam int DEPTH = 4;

  logic hb_clk = 1'b0;
  always #5 hb_clk = ~hb_clk;

  logic            sys_reset_n;
  logic [63:0]     src [NSRC];
  logic [NSRC-1:0] src_sel_n;
  logic [2:0]      swz;
  logic            rd_valid, flush, trdy_n, irdy_n, mst_ad_oe;
  logic [7:0]      hb_byte_ens, mst_c_be;
  logic [63:0]     mst_ad_out;
  logic [NSRC*32-1:0] src32;
  logic [NSRC*64-1:0] src64;

  always_comb begin
    src32 = '0;
    src64 = '0;
    for (int i = 0; i < NSRC; i++) begin
      src32[i*32 +: 32] = src[i][31:0];
      src64[i*64 +: 64] = src[i];
    end
  end

  logic        rdy32, val32, rdy64, val64;
  logic [31:0] dout32;
  logic [63:0] dout64;
  logic [0:0]  par32;
  logic [1:0]  par64;
  logic [2:0]  cnt32, cnt64;

  hbi_dout_pipe #(.DW(32), .NSRC(NSRC), .DEPTH(DEPTH)) u_dut32 (
    .hb_clk(hb_clk), .sys_reset_n(sys_reset_n), .src_data(src32),
    .src_sel_n(src_sel_n), .swizzler_ctrl(swz), .rd_valid(rd_valid),
    .rd_ready(rdy32), .flush(flush), .trdy_n(trdy_n), .irdy_n(irdy_n),
    .hb_byte_ens(hb_byte_ens[3:0]), .mst_ad_oe(mst_ad_oe),
    .mst_ad_out(mst_ad_out[31:0]), .mst_c_be(mst_c_be[3:0]),
    .blkbird_dout(dout32), .dout_valid(val32), .par_out(par32), .fifo_cnt(cnt32));

  hbi_dout_pipe #(.DW(64), .NSRC(NSRC), .DEPTH(DEPTH)) u_dut64 (
    .hb_clk(hb_clk), .sys_reset_n(sys_reset_n), .src_data(src64),
    .src_sel_n(src_sel_n), .swizzler_ctrl(swz), .rd_valid(rd_valid),
    .rd_ready(rdy64), .flush(flush), .trdy_n(trdy_n), .irdy_n(irdy_n),
    .hb_byte_ens(hb_byte_ens), .mst_ad_oe(mst_ad_oe),
    .mst_ad_out(mst_ad_out), .mst_c_be(mst_c_be),
    .blkbird_dout(dout64), .dout_valid(val64), .par_out(par64), .fifo_cnt(cnt64));

  // Reference model state, index 0 = 32-bit instance, 1 = 64-bit instance.
  logic [63:0] m_buf [2][DEPTH];
  int          m_n   [2];
  logic [63:0] m_dout[2];
  logic        m_valid[2];
  logic [1:0]  m_par [2];
  logic        m_oeq [2];

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [63:0] dmask(input int u);
    return (u == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // Output byte j takes input byte (j XOR mode) of the same lane.
  function automatic logic [63:0] model_swz(input logic [63:0] d, input logic [2:0] c);
    logic [63:0] r;
    logic [7:0]  by, rb;
    int          dest;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      by = d[j*8 +: 8];
      rb = by;
      if (c[0]) for (int b = 0; b < 8; b++) rb[b] = by[7-b];
      dest = (j & ~3) | ((j & 3) ^ int'(c[2:1]));
      r[dest*8 +: 8] = rb;
    end
    return r;
  endfunction

  function automatic int pick(input logic [NSRC-1:0] s);
    for (int i = 0; i < NSRC; i++) if (!s[i]) return i;
    return NSRC - 1;
  endfunction

  function automatic logic exp_rdy(input int u);
    return !mst_ad_oe && ((m_n[u] < DEPTH) || (m_valid[u] && !trdy_n && !irdy_n));
  endfunction

  task automatic mreset();
    for (int u = 0; u < 2; u++) begin
      m_n[u] = 0; m_dout[u] = '0; m_valid[u] = 1'b0; m_par[u] = '0; m_oeq[u] = 1'b0;
    end
  endtask

  task automatic mstep(input int u);
    logic        bd, rdy, push;
    logic [63:0] d;
    logic [1:0]  np;
    bd  = m_valid[u] && !trdy_n && !irdy_n;
    rdy = exp_rdy(u);
    np  = m_par[u];
    for (int k = 0; k <= u; k++) begin
      if (m_oeq[u])  np[k] = ^{m_dout[u][k*32 +: 32], mst_c_be[k*4 +: 4]};
      else if (bd)   np[k] = ^{m_dout[u][k*32 +: 32], hb_byte_ens[k*4 +: 4]};
    end
    m_par[u] = np;
    m_oeq[u] = mst_ad_oe;
    d    = model_swz(src[pick(src_sel_n)], swz) & dmask(u);
    push = rd_valid && rdy && !flush;
    if (flush) begin
      m_n[u] = 0;
      m_valid[u] = 1'b0;
      if (mst_ad_oe) m_dout[u] = mst_ad_out & dmask(u);
    end else if (mst_ad_oe && !bd) begin
      m_dout[u] = mst_ad_out & dmask(u);
    end else if (!m_valid[u] || bd) begin
      if (m_n[u] > 0) begin
        m_dout[u]  = m_buf[u][0];
        m_valid[u] = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) m_buf[u][i] = m_buf[u][i+1];
        m_n[u]--;
        if (push) begin m_buf[u][m_n[u]] = d; m_n[u]++; end
      end else if (push) begin
        m_dout[u]  = d;
        m_valid[u] = 1'b1;
      end else begin
        m_valid[u] = 1'b0;
      end
    end else if (push) begin
      m_buf[u][m_n[u]] = d;
      m_n[u]++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, " dout32"},  {32'h0, dout32},  m_dout[0]);
    chk({ph, " valid32"}, {63'h0, val32},   {63'h0, m_valid[0]});
    chk({ph, " par32"},   {63'h0, par32},   {63'h0, m_par[0][0]});
    chk({ph, " cnt32"},   {61'h0, cnt32},   64'(m_n[0]));
    chk({ph, " rdy32"},   {63'h0, rdy32},   {63'h0, exp_rdy(0)});
    chk({ph, " dout64"},  dout64,           m_dout[1]);
    chk({ph, " valid64"}, {63'h0, val64},   {63'h0, m_valid[1]});
    chk({ph, " par64"},   {62'h0, par64},   {62'h0, m_par[1]});
    chk({ph, " cnt64"},   {61'h0, cnt64},   64'(m_n[1]));
    chk({ph, " rdy64"},   {63'h0, rdy64},   {63'h0, exp_rdy(1)});
    chk({ph, " mst_legal"}, {63'h0, mst_ad_oe && val64 && !trdy_n && !irdy_n}, 64'h0);
  endtask

  task automatic step(input string ph);
    @(negedge hb_clk);
    check_all(ph);
    mstep(0);
    mstep(1);
    @(posedge hb_clk);
    #1;
  endtask

  task automatic check_reset_now(input string ph);
    chk({ph, " dout32"},  {32'h0, dout32}, 64'h0);
    chk({ph, " valid32"}, {63'h0, val32},  64'h0);
    chk({ph, " par32"},   {63'h0, par32},  64'h0);
    chk({ph, " cnt32"},   {61'h0, cnt32},  64'h0);
    chk({ph, " rdy32"},   {63'h0, rdy32},  64'h1);
    chk({ph, " dout64"},  dout64,          64'h0);
    chk({ph, " valid64"}, {63'h0, val64},  64'h0);
    chk({ph, " par64"},   {62'h0, par64},  64'h0);
    chk({ph, " cnt64"},   {61'h0, cnt64},  64'h0);
    chk({ph, " rdy64"},   {63'h0, rdy64},  64'h1);
  endtask

  logic [63:0] v;

  initial begin
    sys_reset_n = 1'b0;
    for (int i = 0; i < NSRC; i++) src[i] = '0;
    src_sel_n = '1; swz = 3'b000; rd_valid = 1'b0; flush = 1'b0;
    trdy_n = 1'b1; irdy_n = 1'b1; mst_ad_oe = 1'b0;
    hb_byte_ens = '0; mst_c_be = '0; mst_ad_out = '0;
    mreset();
    @(negedge hb_clk);
    check_all("reset");
    @(posedge hb_clk); #1;
    sys_reset_n = 1'b1;
    step("idle");

    // Source 2, full byte reverse, held through a 3-clock irdy_n stall.
    src[2] = {$urandom, 32'h12345678};
    src_sel_n = 6'b111011; swz = 3'b110;
    hb_byte_ens = 8'($urandom);
    rd_valid = 1'b1; trdy_n = 1'b0; irdy_n = 1'b1;
    step("t1_push");
    rd_valid = 1'b0;
    chk("t1_first", {32'h0, dout32}, 64'h0000_0000_7856_3412);
    for (int i = 0; i < 3; i++) begin
      step("t1_stall");
      chk("t1_hold", {32'h0, dout32}, 64'h0000_0000_7856_3412);
    end
    irdy_n = 1'b0;
    step("t1_beat");
    irdy_n = 1'b1;
    chk("t1_par", {63'h0, par32}, {63'h0, ^{32'h7856_3412, hb_byte_ens[3:0]}});

    // Bit reverse only; sources 0 and 3 both selected, source 0 wins.
    src[0] = {$urandom, 32'h0100_0080};
    src[3] = {$urandom, $urandom};
    src_sel_n = 6'b110110; swz = 3'b001;
    rd_valid = 1'b1;
    step("t2_push");
    rd_valid = 1'b0;
    chk("t2_swz", {32'h0, dout32}, 64'h0000_0000_8000_0001);
    irdy_n = 1'b0;
    step("t2_beat");
    irdy_n = 1'b1;

    // Fill output stage plus FIFO, then a sixth push is refused.
    src_sel_n = '1; swz = 3'($urandom);
    rd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      src[NSRC-1] = {$urandom, $urandom};
      step("t3_fill");
    end
    chk("t3_cnt_full", {61'h0, cnt32}, 64'd4);
    chk("t3_rdy_full", {63'h0, rdy32}, 64'd0);
    src[NSRC-1] = {$urandom, $urandom};
    step("t3_refused");
    src[NSRC-1] = {$urandom, $urandom};
    irdy_n = 1'b0;
    step("t4_push_pop_full");
    chk("t4_cnt", {61'h0, cnt64}, 64'd4);
    rd_valid = 1'b0;
    for (int i = 0; i < 6; i++) step("t3_drain");
    irdy_n = 1'b1;

    // Master write data and its parity one clock later.
    mst_ad_oe = 1'b1;
    mst_ad_out = {$urandom, 32'hA5A5_A5A5};
    mst_c_be = {4'($urandom), 4'b0001};
    step("t5_mst");
    chk("t5_dout", {32'h0, dout32}, 64'h0000_0000_A5A5_A5A5);
    mst_ad_oe = 1'b0;
    step("t5_par");
    chk("t5_par", {63'h0, par32}, 64'h1);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NSRC; i++) src[i] = {$urandom, $urandom};
      src_sel_n   = ($urandom_range(0, 4) == 0) ? '1 : NSRC'($urandom);
      swz         = 3'($urandom);
      rd_valid    = ($urandom_range(0, 2) != 0);
      trdy_n      = ($urandom_range(0, 3) == 0);
      irdy_n      = ($urandom_range(0, 2) == 0);
      hb_byte_ens = 8'($urandom);
      mst_c_be    = 8'($urandom);
      mst_ad_out  = {$urandom, $urandom};
      flush       = ($urandom_range(0, 24) == 0);
      mst_ad_oe   = ($urandom_range(0, 9) == 0);
      if (mst_ad_oe) irdy_n = 1'b1;
      step("rand");
    end

    // Flush mid-burst, then asynchronous reset mid-burst.
    flush = 1'b0; mst_ad_oe = 1'b0; trdy_n = 1'b0; irdy_n = 1'b1; rd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src[pick(src_sel_n)] = {$urandom, $urandom};
      step("t6_fill");
    end
    flush = 1'b1;
    step("t6_flush");
    flush = 1'b0;
    chk("t6_valid", {63'h0, val64}, 64'h0);
    chk("t6_cnt", {61'h0, cnt64}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      src[pick(src_sel_n)] = {$urandom, $urandom};
      step("t6_refill");
    end
    rd_valid = 1'b0;
    #3 sys_reset_n = 1'b0;
    #1 check_reset_now("t6_async_rst");
    mreset();
    @(posedge hb_clk); #1;
    sys_reset_n = 1'b1;
    step("t6_after_rst");

    // Upper-lane parity uses the upper byte enables.
    v = {$urandom, $urandom};
    src[0] = v; src_sel_n = 6'b111110; swz = 3'b000;
    hb_byte_ens = 8'($urandom);
    rd_valid = 1'b1; trdy_n = 1'b0; irdy_n = 1'b1;
    step("t7_push");
    rd_valid = 1'b0; irdy_n = 1'b0;
    step("t7_beat");
    irdy_n = 1'b1;
    chk("t7_par_hi", {63'h0, par64[1]}, {63'h0, ^{v[63:32], hb_byte_ens[7:4]}});
    chk("t7_par_lo", {63'h0, par64[0]}, {63'h0, ^{v[31:0], hb_byte_ens[3:0]}});
    step("t7_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
